// File: rtl/conv_fmap_collector_pkg.sv
// Shared types and default geometry for the feature-map collector.
// The top level re-derives its geometry from its own parameters.
package conv_fmap_pkg;

  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

  localparam int O_DEF  = 112;
  localparam int CH_DEF = 16;
  localparam int PIX    = O_DEF * O_DEF;
  localparam int DEPTH  = PIX * CH_DEF;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = $clog2(PIX);

endpackage

// File: rtl/conv_fmap_collector_if.sv
// Convolver-side sample stream plus pixel-major valid/ready output stream.
interface conv_fmap_collector_if import conv_fmap_pkg::*; #(
  parameter int N     = 16,
  parameter int CH_W  = 5,
  parameter int PIX_W = PW
) ();

  logic             in_valid;
  logic [N-1:0]     in_data;
  logic [CH_W-1:0]  in_channel;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [CH_W-1:0]  out_channel;
  logic [PIX_W-1:0] out_pixel;
  logic             out_last;
  logic             err_channel;
  logic             err_overflow;

  modport slave (
    input  in_valid, in_data, in_channel, out_ready,
    output in_ready, out_valid, out_data, out_channel, out_pixel, out_last,
           err_channel, err_overflow
  );

  modport master (
    output in_valid, in_data, in_channel, out_ready,
    input  in_ready, out_valid, out_data, out_channel, out_pixel, out_last,
           err_channel, err_overflow
  );

endinterface

// File: rtl/conv_fmap_collector_ram.sv
// Simple dual-port feature-map store: one write port, one registered read port.
module fmap_ram import conv_fmap_pkg::*; #(
  parameter int W      = 16,
  parameter int WORDS  = DEPTH,
  parameter int ADDR_W = AW
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data
);

  logic [W-1:0] mem_r [WORDS];

  // Write port and one-cycle registered read port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/conv_fmap_collector.sv
// Collects a channel-sequential feature map and replays it pixel-major.
module conv_fmap_collector import conv_fmap_pkg::*; #(
  parameter int N            = 16,
  parameter int O            = O_DEF,
  parameter int OUT_CHANNELS = CH_DEF,
  parameter int CH_W         = 5
) (
  input logic                   clk,
  input logic                   rst,
  conv_fmap_collector_if.slave  bus
);

  localparam int FRAME_PIX   = O * O;
  localparam int FRAME_DEPTH = FRAME_PIX * OUT_CHANNELS;
  localparam int ADDR_W      = $clog2(FRAME_DEPTH);
  localparam int PIX_W       = $clog2(FRAME_PIX);
  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(FRAME_PIX - 1);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(OUT_CHANNELS - 1);
  localparam logic [ADDR_W-1:0] PIX_STEP = ADDR_W'(FRAME_PIX);

  state_t             state_r, state_s;
  logic [PIX_W-1:0]   pix_r, rd_pix_r, infl_pix_r;
  logic [CH_W-1:0]    exp_ch_r, rd_ch_r, infl_ch_r;
  logic [ADDR_W-1:0]  wr_base_r, rd_addr_r;
  logic               rd_done_r, inflight_r, infl_last_r;
  logic [N-1:0]       rd_data_s;
  logic [N-1:0]       buf_data_r [2];
  logic [CH_W-1:0]    buf_ch_r   [2];
  logic [PIX_W-1:0]   buf_pix_r  [2];
  logic               buf_last_r [2];
  logic               wptr_r, rptr_r;
  logic [1:0]         cnt_r;
  logic               in_ready_r, err_channel_r, err_overflow_r;
  logic               wr_en_s, mismatch_s, overflow_s, last_wr_s;
  logic               pop_s, last_pop_s, issue_s, rd_last_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      COLLECT: if (last_wr_s)  state_s = DRAIN;   else state_s = COLLECT;
      DRAIN:   if (last_pop_s) state_s = COLLECT; else state_s = DRAIN;
      default: state_s = COLLECT;
    endcase
  end

  // Per-cycle control decoded from state and handshakes
  always_comb begin
    wr_en_s    = 1'b0;
    mismatch_s = 1'b0;
    overflow_s = 1'b0;
    issue_s    = 1'b0;
    pop_s      = (cnt_r != 2'd0) && bus.out_ready;
    last_pop_s = pop_s && buf_last_r[rptr_r];
    rd_last_s  = (rd_pix_r == LAST_PIX) && (rd_ch_r == LAST_CH);
    case (state_r)
      COLLECT: begin
        wr_en_s    = bus.in_valid && (bus.in_channel == exp_ch_r);
        mismatch_s = bus.in_valid && (bus.in_channel != exp_ch_r);
      end
      DRAIN: begin
        overflow_s = bus.in_valid;
        // Credit covers the word already in flight out of the RAM
        issue_s    = !rd_done_r && ((({1'b0, inflight_r} + cnt_r) < 2'd2) || pop_s);
      end
      default: begin
        overflow_s = bus.in_valid;
      end
    endcase
    last_wr_s = wr_en_s && (pix_r == LAST_PIX) && (exp_ch_r == LAST_CH);
  end

  // Write address generation for the channel-sequential input
  always_ff @(posedge clk) begin
    if (rst || last_wr_s) begin
      pix_r     <= '0;
      exp_ch_r  <= '0;
      wr_base_r <= '0;
    end else if (wr_en_s) begin
      if (pix_r == LAST_PIX) begin
        pix_r     <= '0;
        exp_ch_r  <= exp_ch_r + CH_W'(1);
        wr_base_r <= wr_base_r + PIX_STEP;
      end else begin
        pix_r <= pix_r + PIX_W'(1);
      end
    end
  end

  // Pixel-major read address generation, stepping by one channel plane
  always_ff @(posedge clk) begin
    if (rst || (state_r == COLLECT)) begin
      rd_pix_r    <= '0;
      rd_ch_r     <= '0;
      rd_addr_r   <= '0;
      rd_done_r   <= 1'b0;
      inflight_r  <= 1'b0;
      infl_pix_r  <= '0;
      infl_ch_r   <= '0;
      infl_last_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        infl_pix_r  <= rd_pix_r;
        infl_ch_r   <= rd_ch_r;
        infl_last_r <= rd_last_s;
        rd_done_r   <= rd_last_s;
        if (rd_ch_r == LAST_CH) begin
          rd_ch_r   <= '0;
          rd_pix_r  <= rd_pix_r + PIX_W'(1);
          rd_addr_r <= ADDR_W'(rd_pix_r) + ADDR_W'(1);
        end else begin
          rd_ch_r   <= rd_ch_r + CH_W'(1);
          rd_addr_r <= rd_addr_r + PIX_STEP;
        end
      end
    end
  end

  fmap_ram #(.W(N), .WORDS(FRAME_DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_base_r + ADDR_W'(pix_r)),
    .wr_data (bus.in_data),
    .rd_en   (issue_s),
    .rd_addr (rd_addr_r),
    .rd_data (rd_data_s)
  );

  // Two-entry output buffer absorbing the RAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= 1'b0;
      rptr_r <= 1'b0;
      cnt_r  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data_r[i] <= '0;
        buf_ch_r[i]   <= '0;
        buf_pix_r[i]  <= '0;
        buf_last_r[i] <= 1'b0;
      end
    end else begin
      if (inflight_r) begin
        buf_data_r[wptr_r] <= rd_data_s;
        buf_ch_r[wptr_r]   <= infl_ch_r;
        buf_pix_r[wptr_r]  <= infl_pix_r;
        buf_last_r[wptr_r] <= infl_last_r;
        wptr_r             <= ~wptr_r;
      end
      if (pop_s) begin
        rptr_r <= ~rptr_r;
      end
      cnt_r <= cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

  // Status flags; errors are sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r     <= 1'b1;
      err_channel_r  <= 1'b0;
      err_overflow_r <= 1'b0;
    end else begin
      in_ready_r     <= (state_s == COLLECT);
      err_channel_r  <= err_channel_r | mismatch_s;
      err_overflow_r <= err_overflow_r | overflow_s;
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = (cnt_r != 2'd0);
  assign bus.out_data     = buf_data_r[rptr_r];
  assign bus.out_channel  = buf_ch_r[rptr_r];
  assign bus.out_pixel    = buf_pix_r[rptr_r];
  assign bus.out_last     = buf_last_r[rptr_r];
  assign bus.err_channel  = err_channel_r;
  assign bus.err_overflow = err_overflow_r;

endmodule

// File: tb/tb_conv_fmap_collector.sv
// Directed bench: small 2x2x3 instance for reorder/stall/error/reset cases,
// 4x4x16 instance for back-to-back gapped frames.
module tb_conv_fmap_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_fmap_collector_if #(.N(16), .CH_W(5), .PIX_W(2)) ia ();
  conv_fmap_collector_if #(.N(16), .CH_W(5), .PIX_W(4)) ib ();

  conv_fmap_collector #(.N(16), .O(2), .OUT_CHANNELS(3), .CH_W(5)) dut_a (
    .clk (clk), .rst (rst), .bus (ia.slave));

  conv_fmap_collector #(.N(16), .O(4), .OUT_CHANNELS(16), .CH_W(5)) dut_b (
    .clk (clk), .rst (rst), .bus (ib.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame into instance A; value 16*ch+p; checks the 2-cycle first-word latency
  task automatic send_a();
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 4; p++) begin
        ia.in_valid   = 1'b1;
        ia.in_data    = 16'(16 * c + p);
        ia.in_channel = 5'(c);
        step();
      end
    end
    ia.in_valid = 1'b0;
    chk("a_valid_at_last_write", 32'(ia.out_valid), 32'd0);
    chk("a_in_ready_drain", 32'(ia.in_ready), 32'd0);
    step();
    chk("a_valid_plus1", 32'(ia.out_valid), 32'd0);
    step();
    chk("a_valid_plus2", 32'(ia.out_valid), 32'd1);
  endtask

  // mode 0: ready high; 1: stall pattern; 2: ready high plus overflow injection
  task automatic drain_a(input int mode, input int nwords);
    logic [39:0] pat;
    int k;
    int cyc;
    logic stalled;
    logic [15:0] s_data;
    logic [4:0]  s_ch;
    logic [1:0]  s_pix;
    logic        s_last;
    pat = 40'b1101_0110_0000_1011_1001_1000_0011_1101_0000_0111;
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    s_data = '0; s_ch = '0; s_pix = '0; s_last = 1'b0;
    while (k < nwords && cyc < 200) begin
      if (stalled) begin
        chk("a_stall_valid", 32'(ia.out_valid), 32'd1);
        chk("a_stall_data", 32'(ia.out_data), 32'(s_data));
        chk("a_stall_ch", 32'(ia.out_channel), 32'(s_ch));
        chk("a_stall_pix", 32'(ia.out_pixel), 32'(s_pix));
        chk("a_stall_last", 32'(ia.out_last), 32'(s_last));
      end
      ia.out_ready = (mode == 1) ? pat[cyc % 40] : 1'b1;
      ia.in_valid  = (mode == 2) && (cyc < 4);
      ia.in_data   = 16'hFFFF;
      ia.in_channel = 5'd0;
      stalled = ia.out_valid && !ia.out_ready;
      s_data = ia.out_data; s_ch = ia.out_channel; s_pix = ia.out_pixel; s_last = ia.out_last;
      if (ia.out_valid && ia.out_ready) begin
        chk("a_data", 32'(ia.out_data), 32'(16 * (k % 3) + k / 3));
        chk("a_ch", 32'(ia.out_channel), 32'(k % 3));
        chk("a_pix", 32'(ia.out_pixel), 32'(k / 3));
        chk("a_last", 32'(ia.out_last), 32'(k == 11));
        chk("a_in_ready_low", 32'(ia.in_ready), 32'd0);
        k++;
      end
      step();
      cyc++;
    end
    ia.in_valid = 1'b0;
    chk("a_drain_count", 32'(k), 32'(nwords));
  endtask

  task automatic send_b(input logic [15:0] xr);
    for (int c = 0; c < 16; c++) begin
      for (int p = 0; p < 16; p++) begin
        ib.in_valid   = 1'b1;
        ib.in_data    = 16'(16 * c + p) ^ xr;
        ib.in_channel = 5'(c);
        step();
        ib.in_valid = 1'b0;
        step();
        step();
      end
    end
  endtask

  task automatic drain_b(input logic [15:0] xr);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    ib.out_ready = 1'b1;
    while (k < 256 && cyc < 1000) begin
      if (ib.out_valid) begin
        chk("b_data", 32'(ib.out_data), 32'(16'(16 * (k % 16) + k / 16) ^ xr));
        chk("b_ch", 32'(ib.out_channel), 32'(k % 16));
        chk("b_pix", 32'(ib.out_pixel), 32'(k / 16));
        chk("b_last", 32'(ib.out_last), 32'(k == 255));
        k++;
      end
      step();
      cyc++;
    end
    ib.out_ready = 1'b0;
    chk("b_drain_count", 32'(k), 32'd256);
    chk("b_back_to_collect", 32'(ib.in_ready), 32'd1);
  endtask

  initial begin
    ia.in_valid = 1'b0; ia.in_data = '0; ia.in_channel = '0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.in_channel = '0; ib.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(ia.in_ready), 32'd1);
    chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("rst_out_data", 32'(ia.out_data), 32'd0);
    chk("rst_out_last", 32'(ia.out_last), 32'd0);
    chk("rst_err_ch", 32'(ia.err_channel), 32'd0);
    chk("rst_err_ovf", 32'(ia.err_overflow), 32'd0);

    // Basic reorder
    send_a();
    drain_a(0, 12);
    chk("a_ready_after_frame", 32'(ia.in_ready), 32'd1);
    chk("a_valid_after_frame", 32'(ia.out_valid), 32'd0);
    chk("a_no_err_ch", 32'(ia.err_channel), 32'd0);
    chk("a_no_err_ovf", 32'(ia.err_overflow), 32'd0);

    // Backpressure with long stall stretches
    send_a();
    drain_a(1, 12);

    // Channel mismatch: stray channel 2 sample while expecting channel 0
    ia.in_valid = 1'b1; ia.in_data = 16'hBEEF; ia.in_channel = 5'd2;
    step();
    ia.in_valid = 1'b0;
    chk("a_err_channel", 32'(ia.err_channel), 32'd1);
    send_a();
    drain_a(0, 12);

    // Overflow during drain
    send_a();
    drain_a(2, 12);
    chk("a_err_overflow", 32'(ia.err_overflow), 32'd1);
    chk("a_err_channel_sticky", 32'(ia.err_channel), 32'd1);

    // Reset after five handshakes, then a clean frame
    send_a();
    drain_a(0, 5);
    rst = 1'b1;
    ia.out_ready = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(ia.in_ready), 32'd1);
    chk("mid_rst_err_ch", 32'(ia.err_channel), 32'd0);
    chk("mid_rst_err_ovf", 32'(ia.err_overflow), 32'd0);
    send_a();
    drain_a(0, 12);

    // Larger geometry, back-to-back gapped frames
    send_b(16'h0000);
    drain_b(16'h0000);
    send_b(16'hA5A5);
    drain_b(16'hA5A5);
    chk("b_no_err_ch", 32'(ib.err_channel), 32'd0);
    chk("b_no_err_ovf", 32'(ib.err_overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_fmap_collector.md
Name: conv_fmap_collector

Overview:
- Receiving end of the convolver output stream: captures {conv_out, channel_out, valid_out} samples.
- Convolver emits channel-sequential data: all o*o pixels of channel 0, then all of channel 1, and so on.
- Stores one full feature map, then replays it pixel-major (all channels of pixel 0, then pixel 1, ...) to the next layer over a valid/ready interface.
- Sits between the first-block convolver and the downstream normalisation/activation stage.

Parameters:
N, 16, sample width (Q8.8 fixed point, passed through untouched)
O, 112, output feature-map side; one channel holds O*O pixels
OUT_CHANNELS, 16, number of channels per frame
CH_W, 5, width of the channel index ports

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
in_valid  in  1  sample strobe from the convolver (no backpressure)
in_data  in  N  sample value
in_channel  in  CH_W  channel of the sample
in_ready  out  1  high while COLLECT; informational only
out_valid  out  1  output word available
out_ready  in  1  downstream accepts the word
out_data  out  N  stored sample
out_channel  out  CH_W  channel of out_data
out_pixel  out  clog2(O*O)  pixel index of out_data
out_last  out  1  high with the final word of the frame
err_channel  out  1  sticky: in_channel mismatched the expected channel
err_overflow  out  1  sticky: in_valid seen while not collecting

Behaviour:
- Reset: all outputs 0, except in_ready=1. State COLLECT; pixel and channel counters 0. A reset mid-frame or mid-drain abandons the data. RAM contents are don't-care.
- COLLECT: on in_valid with in_channel==exp_ch:
  - Write in_data to address exp_ch*O*O + pix.
  - pix increments. When pix==O*O-1 it wraps to 0 and exp_ch increments.
  - The write of pixel O*O-1 of channel OUT_CHANNELS-1 moves the state to DRAIN on the next edge.
- Channel mismatch: if in_valid and in_channel!=exp_ch, the sample is dropped, counters are unchanged and err_channel is set.
- DRAIN:
  - Read order: for p in 0..O*O-1, for c in 0..OUT_CHANNELS-1, address = c*O*O+p.
  - RAM read latency is 1 cycle. A 2-entry output buffer hides it, giving one word per cycle while out_ready is held high.
  - First out_valid appears exactly 2 cycles after the final input write edge.
  - out_data, out_channel, out_pixel and out_last stay stable while out_valid && !out_ready.
  - out_valid never drops without a handshake.
  - Handshake of the word with out_last=1 returns the state to COLLECT on the same edge: in_ready=1 next cycle, counters cleared.
- in_valid outside COLLECT: sample dropped, err_overflow set.
- Error flags clear only on rst.
- Frame is complete only after O*O*OUT_CHANNELS accepted samples; there is no timeout.

Decomposition:
- Package conv_fmap_pkg: state enum {COLLECT, DRAIN}; localparams PIX = O*O, DEPTH = PIX*OUT_CHANNELS, AW = clog2(DEPTH), PW = clog2(PIX).
- Sub-module fmap_ram: simple dual-port synchronous RAM, DEPTH x N, one write port, one registered read port, read-during-write to a different address only.
- Top level holds the FSM, write/read address generators (multiply by constant O*O; increment by O*O in the read loop to avoid a multiplier) and the output skid buffer.

Test Plan (O=2, OUT_CHANNELS=3 unless noted):
- Basic reorder: drive 12 samples, value = 16*ch+p, ch 0..2, p 0..3, out_ready=1 → out_data sequence 0x00,0x10,0x20,0x01,0x11,0x21,0x02,0x12,0x22,0x03,0x13,0x23; out_last only on 0x23; first out_valid 2 cycles after the last write.
- Backpressure: same input, toggle out_ready randomly (including 5-cycle low stretches) → identical 12-word sequence, no drops or duplicates, outputs stable while stalled.
- Channel mismatch: inject in_channel=2 while expecting 0 → err_channel=1 and sample ignored; remaining 12 correct samples still produce the full correct drain.
- Overflow: assert in_valid with data 0xFFFF during DRAIN → err_overflow=1, drained data unchanged, in_ready=0 throughout DRAIN.
- Reset mid-drain: assert rst after 5 handshakes → next cycle out_valid=0, flags 0, in_ready=1; a new 12-sample frame drains correctly from word 0.
- Back-to-back frames with gapped in_valid (1 in 3 cycles), OUT_CHANNELS=16, O=4 → two full 256-word drains in correct pixel-major order, out_pixel counting 0..15.
